cpu_axi_bridge: RTL and testbench

// Converts the CPU's two sram-like ports (inst: read-only, data: read/write) into a single AXI3 master.

---
 rtl/cpu_axi_bridge.sv | 193 +++++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU's sram-like inst/data ports onto one single-beat AXI3 master.
// One outstanding read (inst or data) plus one outstanding data write.
module cpu_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} wstate_e;

  rstate_e     rstate_q, rstate_d;
  wstate_e     wstate_q, wstate_d;
  logic [31:0] raddr_q, waddr_q, wdata_q;
  logic [1:0]  rsize_q, wsize_q;
  logic [3:0]  rid_q, wstrb_q;
  logic        aw_done_q, w_done_q;

  logic r_idle, w_idle, data_rd_acc, data_wr_acc, inst_acc, rd_done;

  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                           rid, rresp, rlast, bid, bresp};

  assign r_idle      = (rstate_q == R_IDLE);
  assign w_idle      = (wstate_q == W_IDLE);
  // Data port keeps at most one transaction in flight; data wins the read slot over inst.
  assign data_rd_acc = data_sram_req & ~data_sram_wr & r_idle & w_idle;
  assign data_wr_acc = data_sram_req & data_sram_wr & w_idle & ~(~r_idle & (rid_q == ID_DATA));
  assign inst_acc    = inst_sram_req & r_idle & ~data_rd_acc;
  assign rd_done     = (rstate_q == R_WAIT) & rvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rsize_q  <= '0;
      rid_q    <= '0;
    end else begin
      rstate_q <= rstate_d;
      if (data_rd_acc) begin
        raddr_q <= data_sram_addr;
        rsize_q <= data_sram_size;
        rid_q   <= ID_DATA;
      end else if (inst_acc) begin
        raddr_q <= inst_sram_addr;
        rsize_q <= inst_sram_size;
        rid_q   <= ID_INST;
      end
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (data_rd_acc | inst_acc) rstate_d = R_AR;
      R_AR:    if (arready) rstate_d = R_WAIT;
      R_WAIT:  if (rvalid) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate_q  <= W_IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wsize_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      if (data_wr_acc) begin
        waddr_q   <= data_sram_addr;
        wdata_q   <= data_sram_wdata;
        wsize_q   <= data_sram_size;
        wstrb_q   <= data_sram_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else if (wstate_q == W_REQ) begin
        if (awready) aw_done_q <= 1'b1;
        if (wready)  w_done_q  <= 1'b1;
      end
    end
  end

  // AW and W complete independently; leave W_REQ once both have handshaken.
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (data_wr_acc) wstate_d = W_REQ;
      W_REQ:   if ((aw_done_q | awready) & (w_done_q | wready)) wstate_d = W_B;
      W_B:     if (bvalid) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    arvalid           = (rstate_q == R_AR);
    rready            = (rstate_q == R_WAIT);
    awvalid           = (wstate_q == W_REQ) & ~aw_done_q;
    wvalid            = (wstate_q == W_REQ) & ~w_done_q;
    bready            = (wstate_q == W_B);
    inst_sram_addr_ok = inst_acc;
    data_sram_addr_ok = data_rd_acc | data_wr_acc;
    inst_sram_data_ok = rd_done & (rid_q == ID_INST);
    data_sram_data_ok = (rd_done & (rid_q == ID_DATA)) | ((wstate_q == W_B) & bvalid);
  end

  assign inst_sram_rdata = rdata;
  assign data_sram_rdata = rdata;

  assign arid    = rid_q;
  assign araddr  = raddr_q;
  assign arlen   = '0;
  assign arsize  = {1'b0, rsize_q};
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  assign awid    = ID_DATA;
  assign awaddr  = waddr_q;
  assign awlen   = '0;
  assign awsize  = {1'b0, wsize_q};
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

  assign wid     = ID_DATA;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Scoreboarded bench for cpu_axi_bridge: expected returns queued at request
// acceptance and retired by a monitor on each data_ok pulse.
module tb_cpu_axi_bridge;

  localparam logic [3:0] ID_I = 4'd0;
  localparam logic [3:0] ID_D = 4'd1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int errors = 0;
  logic [32:0] inst_q[$];
  logic [32:0] data_q[$];
  logic [32:0] e_i, e_d;
  int waited;

  cpu_axi_bridge #(.ID_INST(ID_I), .ID_DATA(ID_D)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard retirement: bit 32 marks a write completion (no rdata compare).
  always @(negedge clk) begin
    if (inst_sram_data_ok) begin
      if (inst_q.size() == 0) check("inst_dok_unexpected", 32'd1, 32'd0);
      else begin
        e_i = inst_q.pop_front();
        check("inst_rdata", inst_sram_rdata, e_i[31:0]);
      end
    end
    if (data_sram_data_ok) begin
      if (data_q.size() == 0) check("data_dok_unexpected", 32'd1, 32'd0);
      else begin
        e_d = data_q.pop_front();
        if (!e_d[32]) check("data_rdata", data_sram_rdata, e_d[31:0]);
      end
    end
  end

  // Entered at posedge+1 with the read already accepted; leaves at posedge+1
  // of the cycle after the R handshake.
  task automatic serve_read(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] sz,
                            input logic [31:0] data, input int lat, output int n);
    n = 0;
    arready = 1'b1;
    @(negedge clk);
    while (!arvalid && n < 20) begin
      cyc();
      @(negedge clk);
      n++;
    end
    check("arvalid", {31'd0, arvalid}, 32'd1);
    check("arid", {28'd0, arid}, {28'd0, id});
    check("araddr", araddr, addr);
    check("arsize", {29'd0, arsize}, {29'd0, sz});
    cyc();
    arready = 1'b0;
    repeat (lat) begin
      @(negedge clk);
      check("rready_wait", {31'd0, rready}, 32'd1);
      check("dok_early", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
      check("inst_aok_busy", {31'd0, inst_sram_addr_ok}, 32'd0);
      cyc();
    end
    rvalid = 1'b1;
    rdata  = data;
    @(negedge clk);
    check("rready_hs", {31'd0, rready}, 32'd1);
    cyc();
    rvalid = 1'b0;
    rdata  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    {inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata} = '0;
    {data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata} = '0;
    {arready, rvalid, rlast, awready, wready, bvalid} = '0;
    {rid, rdata, rresp, bid, bresp} = '0;
    inst_sram_size = 2'd2;
    repeat (2) @(negedge clk);
    check("rst_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    check("rst_oks", {28'd0, inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok}, 32'd0);
    #1 resetn = 1'b1;
    cyc();

    // 1: single instruction fetch
    inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc00000;
    @(negedge clk);
    check("t1_aok", {31'd0, inst_sram_addr_ok}, 32'd1);
    check("t1_arvalid_now", {31'd0, arvalid}, 32'd0);
    inst_q.push_back({1'b0, 32'h3c1d0000});
    cyc();
    inst_sram_req = 1'b0;
    serve_read(ID_I, 32'hbfc00000, 3'd2, 32'h3c1d0000, 2, waited);
    check("t1_ar_latency", waited, 32'd0);
    @(negedge clk);
    check("t1_dok_once", {31'd0, inst_sram_data_ok}, 32'd0);
    check("t1_rready_off", {31'd0, rready}, 32'd0);
    cyc();

    // 2: inst and data read collide; data wins
    inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc00004;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h80000010; data_sram_size = 2'd2;
    @(negedge clk);
    check("t2_data_aok", {31'd0, data_sram_addr_ok}, 32'd1);
    check("t2_inst_aok", {31'd0, inst_sram_addr_ok}, 32'd0);
    data_q.push_back({1'b0, 32'h11112222});
    cyc();
    data_sram_req = 1'b0;
    serve_read(ID_D, 32'h80000010, 3'd2, 32'h11112222, 1, waited);
    @(negedge clk);
    check("t2_inst_aok_after", {31'd0, inst_sram_addr_ok}, 32'd1);
    inst_q.push_back({1'b0, 32'h22223333});
    cyc();
    inst_sram_req = 1'b0;
    serve_read(ID_I, 32'hbfc00004, 3'd2, 32'h22223333, 0, waited);

    // 3: halfword write, W accepted at once, AW two cycles later
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd1;
    data_sram_addr = 32'h80001000; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h00001234;
    @(negedge clk);
    check("t3_aok", {31'd0, data_sram_addr_ok}, 32'd1);
    data_q.push_back({1'b1, 32'h0});
    cyc();
    data_sram_req = 1'b0; wready = 1'b1;
    @(negedge clk);
    check("t3_valids", {30'd0, awvalid, wvalid}, 32'd3);
    check("t3_awaddr", awaddr, 32'h80001000);
    check("t3_wdata", wdata, 32'h00001234);
    check("t3_w_fields", {20'd0, wstrb, wid, awid}, {20'd0, 4'b0011, ID_D, ID_D});
    check("t3_aw_fields", {21'd0, wlast, awsize, awlen}, {21'd0, 1'b1, 3'd1, 8'd0});
    cyc();
    wready = 1'b0;
    @(negedge clk);
    check("t3_w_dropped", {30'd0, awvalid, wvalid}, 32'd2);
    cyc();
    awready = 1'b1;
    @(negedge clk);
    check("t3_aw_hold", {30'd0, awvalid, bready}, 32'd2);
    cyc();
    awready = 1'b0;
    @(negedge clk);
    check("t3_wb", {29'd0, awvalid, bready, data_sram_data_ok}, 32'd2);
    cyc();
    bvalid = 1'b1;
    @(negedge clk);
    check("t3_bready", {31'd0, bready}, 32'd1);
    cyc();
    bvalid = 1'b0;
    @(negedge clk);
    check("t3_idle", {30'd0, bready, data_sram_data_ok}, 32'd0);
    cyc();

    // 4: data read held off while the write waits for B
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd2;
    data_sram_addr = 32'h80001004; data_sram_wstrb = 4'hf; data_sram_wdata = 32'ha5a5a5a5;
    @(negedge clk);
    check("t4_wr_aok", {31'd0, data_sram_addr_ok}, 32'd1);
    data_q.push_back({1'b1, 32'h0});
    cyc();
    data_sram_req = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    check("t4_valids", {30'd0, awvalid, wvalid}, 32'd3);
    cyc();
    awready = 1'b0; wready = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h80002000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t4_rd_blocked", {30'd0, data_sram_addr_ok, bready}, 32'd1);
      cyc();
    end
    bvalid = 1'b1;
    @(negedge clk);
    check("t4_rd_blocked_b", {31'd0, data_sram_addr_ok}, 32'd0);
    cyc();
    bvalid = 1'b0;
    @(negedge clk);
    check("t4_rd_aok", {31'd0, data_sram_addr_ok}, 32'd1);
    data_q.push_back({1'b0, 32'hcafef00d});
    cyc();
    data_sram_req = 1'b0;
    serve_read(ID_D, 32'h80002000, 3'd2, 32'hcafef00d, 2, waited);

    // 5: data write overlaps an instruction fetch in R_WAIT
    inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc00100;
    @(negedge clk);
    check("t5_inst_aok", {31'd0, inst_sram_addr_ok}, 32'd1);
    inst_q.push_back({1'b0, 32'h01234567});
    cyc();
    inst_sram_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    check("t5_arvalid", {31'd0, arvalid}, 32'd1);
    cyc();
    arready = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h80003000; data_sram_wdata = 32'h5a5a0000;
    @(negedge clk);
    check("t5_wr_aok", {30'd0, data_sram_addr_ok, rready}, 32'd3);
    data_q.push_back({1'b1, 32'h0});
    cyc();
    data_sram_req = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    check("t5_wvalids", {30'd0, awvalid, wvalid}, 32'd3);
    cyc();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; rvalid = 1'b1; rdata = 32'h01234567;
    @(negedge clk);
    check("t5_both_dok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd3);
    cyc();
    bvalid = 1'b0; rvalid = 1'b0; rdata = '0;
    @(negedge clk);
    check("t5_idle", {28'd0, rready, bready, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    cyc();

    // 6: reset in R_AR discards the fetch
    inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc00200;
    @(negedge clk);
    check("t6_aok", {31'd0, inst_sram_addr_ok}, 32'd1);
    cyc();
    inst_sram_req = 1'b0;
    @(negedge clk);
    check("t6_arvalid", {31'd0, arvalid}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("t6_rst_async", {30'd0, arvalid, rready}, 32'd0);
    rvalid = 1'b1; rdata = 32'hdeadbeef;
    @(negedge clk);
    check("t6_no_dok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    rvalid = 1'b0; rdata = '0;
    #1 resetn = 1'b1;
    cyc();
    inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc00300;
    @(negedge clk);
    check("t6_fresh_aok", {31'd0, inst_sram_addr_ok}, 32'd1);
    inst_q.push_back({1'b0, 32'h76543210});
    cyc();
    inst_sram_req = 1'b0;
    serve_read(ID_I, 32'hbfc00300, 3'd2, 32'h76543210, 1, waited);
    repeat (2) cyc();

    check("sb_inst_empty", inst_q.size(), 32'd0);
    check("sb_data_empty", data_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
